// File: rtl/timer_defs.sv
`default_nettype none
// ============================================================================
// Module   : timer_defs (package)
// Purpose  : State encoding, digit wrap values and BCD field layout shared by
//            the countdown timer and its digit counters.
// Revision : 1.0 - initial release
// ============================================================================
package timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] C_WRAP_9  = 4'd9;
  localparam logic [3:0] C_WRAP_5  = 4'd5;

  localparam int C_DIGIT_W = 4;
  localparam int C_S0_LSB  = 0;
  localparam int C_S1_LSB  = 4;
  localparam int C_M0_LSB  = 8;
  localparam int C_M1_LSB  = 12;

  // Saturate each digit into its legal range: 9 for all, 5 for tens-of-seconds.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[i*C_DIGIT_W +: C_DIGIT_W] > C_WRAP_9) r[i*C_DIGIT_W +: C_DIGIT_W] = C_WRAP_9;
    end
    if (r[C_S1_LSB +: C_DIGIT_W] > C_WRAP_5) r[C_S1_LSB +: C_DIGIT_W] = C_WRAP_5;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_dn.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_dn
// Purpose  : One 4-bit BCD down-counting digit; wraps 0 -> wrap and borrows.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_dn (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] d,
  input  logic [3:0] wrap,
  output logic [3:0] q,
  output logic       borrow_out
);

  assign borrow_out = en & (q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= (q == 4'd0) ? wrap : q - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Purpose  : MM:SS BCD countdown with load/start/pause/resume and alarm.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer
  import timer_defs::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        load,
  input  logic [15:0] set_val,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] num,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int C_PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(TICK_DIV - 1);

  state_t          r_state;
  logic [C_PW-1:0] r_presc;
  logic [15:0]     w_set_clamped;
  logic            w_presc_last;
  logic            w_tick;
  logic            w_is_zero;
  logic            w_next_zero;
  logic [3:0]      w_en;
  logic [3:0]      w_borrow;
  logic            w_unused_borrow;

  assign w_set_clamped = clamp_bcd(set_val);
  assign w_presc_last  = (r_presc == C_PRESC_LAST);
  // The prescaler keeps counting on the edge that pauses, so pausing costs no time.
  assign w_tick        = (r_state == ST_RUN) && !load && w_presc_last;
  assign w_is_zero     = (num == 16'h0000);
  assign w_next_zero   = (num == 16'h0001);

  assign w_en[0]         = w_tick;
  assign w_en[3:1]       = w_borrow[2:0];
  assign w_unused_borrow = w_borrow[3];

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_digit
      localparam logic [3:0] c_wrap = (i * C_DIGIT_W == C_S1_LSB) ? C_WRAP_5 : C_WRAP_9;
      bcd_digit_dn u_digit (
        .clk        (clk),
        .rst        (RST),
        .en         (w_en[i]),
        .load       (load),
        .d          (w_set_clamped[i*C_DIGIT_W +: C_DIGIT_W]),
        .wrap       (c_wrap),
        .q          (num[i*C_DIGIT_W +: C_DIGIT_W]),
        .borrow_out (w_borrow[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        r_state <= ST_IDLE;
        r_presc <= '0;
        running <= 1'b0;
        alarm   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!pause && start && !w_is_zero) begin
              r_state <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            r_presc <= w_presc_last ? '0 : r_presc + C_PW'(1);
            if (w_tick && w_next_zero) begin
              r_state <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
              alarm   <= 1'b1;
            end else if (pause) begin
              r_state <= ST_PAUSE;
              running <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (!pause && start) begin
              r_state <= ST_RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Purpose  : Directed self-checking bench for bcd_countdown_timer (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        load = 1'b0;
  logic [15:0] set_val = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] num;
  logic        running;
  logic        done;
  logic        alarm;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  bcd_countdown_timer #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .RST     (RST),
    .load    (load),
    .set_val (set_val),
    .start   (start),
    .pause   (pause),
    .num     (num),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; set_val = v;
    tick(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk_cnt++;
    if ({num, running, done, alarm} !== {16'h0000, 3'b000})
      $display("FAIL reset_outputs got num=%h r=%b d=%b a=%b want 0000/0/0/0", num, running, done, alarm);
    else pass_cnt++;
    do_start();
    tick(5);
    chk_cnt++;
    if ({num, running, alarm} !== {16'h0000, 2'b00})
      $display("FAIL start_at_zero got num=%h r=%b a=%b want 0000/0/0", num, running, alarm);
    else pass_cnt++;
  endtask

  task automatic test_countdown_done();
    do_load(16'h0003);
    do_start();
    chk_cnt++;
    if (running !== 1'b1) $display("FAIL run_entry got running=%b want 1", running);
    else pass_cnt++;
    tick(3);
    chk_cnt++;
    if (num !== 16'h0003) $display("FAIL pre_first_dec got %h want 0003", num);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (num !== 16'h0002) $display("FAIL dec_plus4 got %h want 0002", num);
    else pass_cnt++;
    tick(4);
    chk_cnt++;
    if (num !== 16'h0001) $display("FAIL dec_plus8 got %h want 0001", num);
    else pass_cnt++;
    tick(3);
    chk_cnt++;
    if ({done, alarm, running} !== 3'b001)
      $display("FAIL pre_zero got d=%b a=%b r=%b want 0/0/1", done, alarm, running);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({num, done, alarm, running} !== {16'h0000, 3'b110})
      $display("FAIL reach_zero got num=%h d=%b a=%b r=%b want 0000/1/1/0", num, done, alarm, running);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if ({num, done, alarm} !== {16'h0000, 2'b01})
      $display("FAIL done_one_cycle got num=%h d=%b a=%b want 0000/0/1", num, done, alarm);
    else pass_cnt++;
  endtask

  task automatic test_borrow_chain();
    do_load(16'h1000);
    chk_cnt++;
    if ({num, alarm} !== {16'h1000, 1'b0}) $display("FAIL load_clears_alarm got num=%h a=%b want 1000/0", num, alarm);
    else pass_cnt++;
    do_start();
    tick(3);
    chk_cnt++;
    if (num !== 16'h1000) $display("FAIL borrow_pre got %h want 1000", num);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (num !== 16'h0959) $display("FAIL borrow_chain got %h want 0959", num);
    else pass_cnt++;
    // Load coincides with the next scheduled decrement: loaded value must win.
    tick(3);
    load = 1'b1; set_val = 16'h0420;
    tick(1);
    load = 1'b0;
    chk_cnt++;
    if ({num, running} !== {16'h0420, 1'b0}) $display("FAIL load_vs_dec got num=%h r=%b want 0420/0", num, running);
    else pass_cnt++;
  endtask

  task automatic test_pause_resume();
    do_load(16'h0002);
    do_start();
    tick(1);
    pause = 1'b1;
    tick(10);
    chk_cnt++;
    if ({num, running} !== {16'h0002, 1'b0}) $display("FAIL paused got num=%h r=%b want 0002/0", num, running);
    else pass_cnt++;
    pause = 1'b0;
    do_start();
    chk_cnt++;
    if (running !== 1'b1) $display("FAIL resume got running=%b want 1", running);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (num !== 16'h0002) $display("FAIL resume_plus13 got %h want 0002", num);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (num !== 16'h0001) $display("FAIL resume_plus14 got %h want 0001", num);
    else pass_cnt++;
    start = 1'b1; pause = 1'b1;
    tick(1);
    start = 1'b0; pause = 1'b0;
    tick(6);
    chk_cnt++;
    if ({num, running} !== {16'h0001, 1'b0}) $display("FAIL start_pause_run got num=%h r=%b want 0001/0", num, running);
    else pass_cnt++;
    load = 1'b1; pause = 1'b1; set_val = 16'h0033;
    tick(1);
    load = 1'b0; pause = 1'b0;
    do_start();
    chk_cnt++;
    if ({num, running} !== {16'h0033, 1'b1}) $display("FAIL load_over_pause got num=%h r=%b want 0033/1", num, running);
    else pass_cnt++;
  endtask

  task automatic test_clamp_done();
    do_load(16'hAB7F);
    chk_cnt++;
    if (num !== 16'h9959) $display("FAIL clamp got %h want 9959", num);
    else pass_cnt++;
    do_load(16'h0001);
    do_start();
    tick(4);
    chk_cnt++;
    if ({num, alarm} !== {16'h0000, 1'b1}) $display("FAIL reach_done got num=%h a=%b want 0000/1", num, alarm);
    else pass_cnt++;
    do_start();
    pause = 1'b1;
    tick(2);
    pause = 1'b0;
    tick(2);
    chk_cnt++;
    if ({num, alarm, running, done} !== {16'h0000, 3'b100})
      $display("FAIL done_ignores_start got num=%h a=%b r=%b d=%b want 0000/1/0/0", num, alarm, running, done);
    else pass_cnt++;
    do_load(16'h0010);
    tick(3);
    chk_cnt++;
    if ({num, alarm, running} !== {16'h0010, 2'b00})
      $display("FAIL reload_from_done got num=%h a=%b r=%b want 0010/0/0", num, alarm, running);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    do_load(16'h0002);
    do_start();
    tick(3);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk_cnt++;
    if ({num, running, done, alarm} !== {16'h0000, 3'b000})
      $display("FAIL reset_mid_run got num=%h r=%b d=%b a=%b want 0000/0/0/0", num, running, done, alarm);
    else pass_cnt++;
    do_load(16'h0005);
    do_start();
    tick(3);
    chk_cnt++;
    if (num !== 16'h0005) $display("FAIL post_reset_pre got %h want 0005", num);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (num !== 16'h0004) $display("FAIL post_reset_dec got %h want 0004", num);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_countdown_done();
    test_borrow_chain();
    test_pause_resume();
    test_clamp_done();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
